// File: rtl/vgachargen_pkg.sv
// Shared types and constants for the APB bridge into the text-mode VGA generator
// memories (character map, colour map, font table).
package vgachargen_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned PADDR_W = 14;
  localparam int unsigned MEM_AW  = 10;

  // 80x30 bytes packed four per word; 256 glyphs x 16 rows of 8 bits
  localparam int unsigned CH_MAP_WORDS_DEF  = 600;
  localparam int unsigned COL_MAP_WORDS_DEF = 600;
  localparam int unsigned CH_T_WORDS_DEF    = 1024;

  localparam logic [PADDR_W-1:0] CH_MAP_BASE  = 14'h0000;
  localparam logic [PADDR_W-1:0] COL_MAP_BASE = 14'h1000;
  localparam logic [PADDR_W-1:0] CH_T_BASE    = 14'h2000;

  typedef enum logic [1:0] {
    CH_MAP  = 2'd0,
    COL_MAP = 2'd1,
    CH_T    = 2'd2,
    NONE    = 2'd3
  } region_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } apb_state_e;

  // One-hot write-enable vector, bit order {ch_t, col_map, ch_map}
  function automatic logic [2:0] region_onehot(input region_e r);
    logic [2:0] oh;
    oh = 3'b000;
    case (r)
      CH_MAP:  oh = 3'b001;
      COL_MAP: oh = 3'b010;
      CH_T:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/vgachargen_apb_decode.sv
// Address decoder: splits an APB byte address into target region and word offset
// and flags addresses outside the populated part of each region.
module vgachargen_apb_decode
  import vgachargen_pkg::*;
#(
  parameter int unsigned CH_MAP_WORDS  = CH_MAP_WORDS_DEF,
  parameter int unsigned COL_MAP_WORDS = COL_MAP_WORDS_DEF,
  parameter int unsigned CH_T_WORDS    = CH_T_WORDS_DEF
) (
  input  logic [PADDR_W-1:0] paddr_i,
  output region_e            region_o,
  output logic [MEM_AW-1:0]  offset_o,
  output logic               legal_o
);

  // Byte lane bits carry no information for word accesses
  logic [1:0] unused_byte_lane;
  assign unused_byte_lane = paddr_i[1:0];

  assign offset_o = paddr_i[11:2];

  always_comb begin
    region_o = NONE;
    legal_o  = 1'b0;
    if (paddr_i[13:12] == CH_MAP_BASE[13:12]) begin
      region_o = CH_MAP;
      legal_o  = 32'(offset_o) < CH_MAP_WORDS;
    end else if (paddr_i[13:12] == COL_MAP_BASE[13:12]) begin
      region_o = COL_MAP;
      legal_o  = 32'(offset_o) < COL_MAP_WORDS;
    end else if (paddr_i[13:12] == CH_T_BASE[13:12]) begin
      region_o = CH_T;
      legal_o  = 32'(offset_o) < CH_T_WORDS;
    end
  end

endmodule

// File: rtl/vgachargen_apb_if.sv
// APB4 completer in front of the VGA generator memories: zero-wait writes,
// one-wait reads to absorb the synchronous memory latency.
//
// state      | meaning
// ST_IDLE    | waiting for / serving an ACCESS cycle (writes and errors finish here)
// ST_RD_WAIT | memory read data valid, completing the read
module vgachargen_apb_if
  import vgachargen_pkg::*;
#(
  parameter int unsigned CH_MAP_WORDS  = CH_MAP_WORDS_DEF,
  parameter int unsigned COL_MAP_WORDS = COL_MAP_WORDS_DEF,
  parameter int unsigned CH_T_WORDS    = CH_T_WORDS_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [PADDR_W-1:0]  paddr_i,
  input  logic [DATA_W-1:0]   pwdata_i,
  input  logic [STRB_W-1:0]   pstrb_i,
  output logic [DATA_W-1:0]   prdata_o,
  output logic                pready_o,
  output logic                pslverr_o,

  output logic [MEM_AW-1:0]   ch_map_addr_o,
  output logic [DATA_W-1:0]   ch_map_wdata_o,
  output logic [STRB_W-1:0]   ch_map_be_o,
  output logic                ch_map_wen_o,
  input  logic [DATA_W-1:0]   ch_map_rdata_i,

  output logic [MEM_AW-1:0]   col_map_addr_o,
  output logic [DATA_W-1:0]   col_map_wdata_o,
  output logic [STRB_W-1:0]   col_map_be_o,
  output logic                col_map_wen_o,
  input  logic [DATA_W-1:0]   col_map_rdata_i,

  output logic [MEM_AW-1:0]   ch_t_addr_o,
  output logic [DATA_W-1:0]   ch_t_wdata_o,
  output logic [STRB_W-1:0]   ch_t_be_o,
  output logic                ch_t_wen_o,
  input  logic [DATA_W-1:0]   ch_t_rdata_i
);

  apb_state_e          state_q, state_d;
  region_e             region_q, region_d;
  region_e             dec_region;
  logic [MEM_AW-1:0]   dec_offset;
  logic                dec_legal;
  logic                access;
  logic [2:0]          wen;
  logic [DATA_W-1:0]   rdata_sel;

  logic [MEM_AW-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [STRB_W-1:0]   mem_be_q;

  vgachargen_apb_decode #(
    .CH_MAP_WORDS  (CH_MAP_WORDS),
    .COL_MAP_WORDS (COL_MAP_WORDS),
    .CH_T_WORDS    (CH_T_WORDS)
  ) u_decode (
    .paddr_i  (paddr_i),
    .region_o (dec_region),
    .offset_o (dec_offset),
    .legal_o  (dec_legal)
  );

  // Reset also masks the combinational responses so nothing leaks while held in reset
  assign access = rst_ni & psel_i & penable_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      region_q <= CH_MAP;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
    end
  end

  // Captured during SETUP so address/data are already stable at the memories in ACCESS
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else if (psel_i) begin
      mem_addr_q  <= dec_offset;
      mem_wdata_q <= pwdata_i;
      mem_be_q    <= pstrb_i;
    end
  end

  always_comb begin
    rdata_sel = '0;
    case (region_q)
      CH_MAP:  rdata_sel = ch_map_rdata_i;
      COL_MAP: rdata_sel = col_map_rdata_i;
      CH_T:    rdata_sel = ch_t_rdata_i;
      default: rdata_sel = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    prdata_o  = '0;
    wen       = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (!dec_legal) begin
            pready_o  = 1'b1;
            pslverr_o = 1'b1;
          end else if (pwrite_i) begin
            pready_o = 1'b1;
            if (|pstrb_i) wen = region_onehot(dec_region);
          end else begin
            state_d  = ST_RD_WAIT;
            region_d = dec_region;
          end
        end
      end
      ST_RD_WAIT: begin
        state_d = ST_IDLE;
        // A master that drops psel here gets no response at all
        if (rst_ni & psel_i) begin
          pready_o = 1'b1;
          prdata_o = rdata_sel;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ch_map_wen_o    = wen[0];
  assign col_map_wen_o   = wen[1];
  assign ch_t_wen_o      = wen[2];

  assign ch_map_addr_o   = mem_addr_q;
  assign col_map_addr_o  = mem_addr_q;
  assign ch_t_addr_o     = mem_addr_q;

  assign ch_map_wdata_o  = mem_wdata_q;
  assign col_map_wdata_o = mem_wdata_q;
  assign ch_t_wdata_o    = mem_wdata_q;

  assign ch_map_be_o     = mem_be_q;
  assign col_map_be_o    = mem_be_q;
  assign ch_t_be_o       = mem_be_q;

endmodule

// File: tb/tb_vgachargen_apb_if.sv
// Directed bench for the VGA memory APB bridge, with simple synchronous memory
// models behind the three memory ports.
module tb_vgachargen_apb_if;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        psel_i, penable_i, pwrite_i;
  logic [13:0] paddr_i;
  logic [31:0] pwdata_i;
  logic [3:0]  pstrb_i;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic [9:0]  ch_map_addr_o, col_map_addr_o, ch_t_addr_o;
  logic [31:0] ch_map_wdata_o, col_map_wdata_o, ch_t_wdata_o;
  logic [3:0]  ch_map_be_o, col_map_be_o, ch_t_be_o;
  logic        ch_map_wen_o, col_map_wen_o, ch_t_wen_o;
  logic [31:0] ch_map_rdata_i, col_map_rdata_i, ch_t_rdata_i;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  vgachargen_apb_if dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i), .paddr_i(paddr_i),
    .pwdata_i(pwdata_i), .pstrb_i(pstrb_i), .prdata_o(prdata_o), .pready_o(pready_o),
    .pslverr_o(pslverr_o),
    .ch_map_addr_o(ch_map_addr_o), .ch_map_wdata_o(ch_map_wdata_o), .ch_map_be_o(ch_map_be_o),
    .ch_map_wen_o(ch_map_wen_o), .ch_map_rdata_i(ch_map_rdata_i),
    .col_map_addr_o(col_map_addr_o), .col_map_wdata_o(col_map_wdata_o), .col_map_be_o(col_map_be_o),
    .col_map_wen_o(col_map_wen_o), .col_map_rdata_i(col_map_rdata_i),
    .ch_t_addr_o(ch_t_addr_o), .ch_t_wdata_o(ch_t_wdata_o), .ch_t_be_o(ch_t_be_o),
    .ch_t_wen_o(ch_t_wen_o), .ch_t_rdata_i(ch_t_rdata_i)
  );

  // Synchronous memories: write on the edge with wen, read data one cycle after address
  logic [31:0] mem_ch [1024];
  logic [31:0] mem_col[1024];
  logic [31:0] mem_cht[1024];
  logic        mem_clr;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk_i) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) begin
        mem_ch[i]  <= '0;
        mem_col[i] <= '0;
        mem_cht[i] <= '0;
      end
    end else begin
      if (ch_map_wen_o)  mem_ch[ch_map_addr_o]  <= merge(mem_ch[ch_map_addr_o], ch_map_wdata_o, ch_map_be_o);
      if (col_map_wen_o) mem_col[col_map_addr_o] <= merge(mem_col[col_map_addr_o], col_map_wdata_o, col_map_be_o);
      if (ch_t_wen_o)    mem_cht[ch_t_addr_o]    <= merge(mem_cht[ch_t_addr_o], ch_t_wdata_o, ch_t_be_o);
    end
    ch_map_rdata_i  <= mem_ch[ch_map_addr_o];
    col_map_rdata_i <= mem_col[col_map_addr_o];
    ch_t_rdata_i    <= mem_cht[ch_t_addr_o];
  end

  // Observations from the last transfer
  logic        o_setup_ready, o_ready, o_err, o_idle_ready, o_idle_err;
  logic [31:0] o_rdata, o_wdata;
  logic [2:0]  o_wen;
  logic [9:0]  o_ch_addr, o_col_addr, o_cht_addr;
  logic [3:0]  o_ch_be, o_col_be;
  int          o_waits, o_wen_cnt;

  task automatic xfer(input logic wr, input logic [13:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic idle_after);
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr; pwdata_i = data; pstrb_i = strb;
    #2 o_setup_ready = pready_o;
    o_wen_cnt = int'(ch_map_wen_o | col_map_wen_o | ch_t_wen_o);
    @(negedge clk_i);
    penable_i = 1'b1;
    #2;
    o_wen = {ch_t_wen_o, col_map_wen_o, ch_map_wen_o};
    o_wen_cnt += int'(|o_wen);
    o_ch_addr = ch_map_addr_o; o_col_addr = col_map_addr_o; o_cht_addr = ch_t_addr_o;
    o_ch_be = ch_map_be_o; o_col_be = col_map_be_o; o_wdata = ch_t_wdata_o;
    o_waits = 0;
    while (!pready_o && o_waits < 4) begin
      @(negedge clk_i);
      #2;
      o_waits++;
      o_wen_cnt += int'(ch_map_wen_o | col_map_wen_o | ch_t_wen_o);
    end
    o_ready = pready_o; o_err = pslverr_o; o_rdata = prdata_o;
    o_idle_ready = 1'b0; o_idle_err = 1'b0;
    if (idle_after) begin
      @(negedge clk_i);
      psel_i = 1'b0; penable_i = 1'b0;
      #2 o_idle_ready = pready_o; o_idle_err = pslverr_o;
      o_wen_cnt += int'(ch_map_wen_o | col_map_wen_o | ch_t_wen_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    psel_i = 1'b1; penable_i = 1'b1; pwrite_i = 1'b1; paddr_i = 14'h3000;
    pwdata_i = 32'hFFFF_FFFF; pstrb_i = 4'hF;
    #2;
    vectors++; if (pready_o !== 1'b0) begin miscompares++; $display("FAIL rst_pready: got %b want 0", pready_o); end
    vectors++; if (pslverr_o !== 1'b0) begin miscompares++; $display("FAIL rst_pslverr: got %b want 0", pslverr_o); end
    vectors++; if (prdata_o !== 32'h0) begin miscompares++; $display("FAIL rst_prdata: got %h want 0", prdata_o); end
    vectors++; if ({ch_map_wen_o, col_map_wen_o, ch_t_wen_o} !== 3'b000) begin miscompares++; $display("FAIL rst_wen: got %b want 000", {ch_map_wen_o, col_map_wen_o, ch_t_wen_o}); end
    vectors++; if ({ch_map_addr_o, col_map_addr_o, ch_t_addr_o} !== 30'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", {ch_map_addr_o, col_map_addr_o, ch_t_addr_o}); end
    vectors++; if ({ch_map_be_o, col_map_be_o, ch_t_be_o} !== 12'h0) begin miscompares++; $display("FAIL rst_be: got %h want 0", {ch_map_be_o, col_map_be_o, ch_t_be_o}); end
    vectors++; if ({ch_map_wdata_o, col_map_wdata_o, ch_t_wdata_o} !== 96'h0) begin miscompares++; $display("FAIL rst_wdata: got %h want 0", {ch_map_wdata_o, col_map_wdata_o, ch_t_wdata_o}); end
    @(negedge clk_i);
    psel_i = 1'b0; penable_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_write_ch_map();
    xfer(1'b1, 14'h0004, 32'h4142_4344, 4'hF, 1'b1);
    vectors++; if (o_setup_ready !== 1'b0) begin miscompares++; $display("FAIL wch_setup_pready: got %b want 0", o_setup_ready); end
    vectors++; if (o_ready !== 1'b1 || o_waits != 0) begin miscompares++; $display("FAIL wch_pready: got %b waits %0d want 1 waits 0", o_ready, o_waits); end
    vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL wch_pslverr: got %b want 0", o_err); end
    vectors++; if (o_wen !== 3'b001 || o_wen_cnt != 1) begin miscompares++; $display("FAIL wch_wen: got %b cnt %0d want 001 cnt 1", o_wen, o_wen_cnt); end
    vectors++; if (o_ch_addr !== 10'd1 || o_ch_be !== 4'hF) begin miscompares++; $display("FAIL wch_addr_be: got %0d/%h want 1/f", o_ch_addr, o_ch_be); end
    vectors++; if (o_wdata !== 32'h4142_4344) begin miscompares++; $display("FAIL wch_wdata: got %h want 41424344", o_wdata); end
    vectors++; if (o_idle_ready !== 1'b0 || o_idle_err !== 1'b0) begin miscompares++; $display("FAIL wch_idle_pulse: got %b%b want 00", o_idle_ready, o_idle_err); end
    xfer(1'b0, 14'h0004, 32'h0, 4'h0, 1'b1);
    vectors++; if (o_ready !== 1'b1 || o_waits != 1) begin miscompares++; $display("FAIL rch_wait: got ready %b waits %0d want 1 waits 1", o_ready, o_waits); end
    vectors++; if (o_rdata !== 32'h4142_4344 || o_err !== 1'b0) begin miscompares++; $display("FAIL rch_data: got %h err %b want 41424344 err 0", o_rdata, o_err); end
    vectors++; if (o_wen_cnt != 0) begin miscompares++; $display("FAIL rch_no_wen: got %0d want 0", o_wen_cnt); end
  endtask

  task automatic test_partial_strobe();
    xfer(1'b1, 14'h1010, 32'hAABB_CCDD, 4'h5, 1'b1);
    vectors++; if (o_col_be !== 4'h5 || o_col_addr !== 10'd4) begin miscompares++; $display("FAIL wcol_be_addr: got %h/%0d want 5/4", o_col_be, o_col_addr); end
    vectors++; if (o_wen !== 3'b010 || o_wen_cnt != 1) begin miscompares++; $display("FAIL wcol_wen: got %b cnt %0d want 010 cnt 1", o_wen, o_wen_cnt); end
    xfer(1'b0, 14'h1010, 32'h0, 4'hF, 1'b1);
    vectors++; if (o_rdata !== 32'h00BB_00DD || o_waits != 1) begin miscompares++; $display("FAIL rcol_data: got %h waits %0d want 00bb00dd waits 1", o_rdata, o_waits); end
  endtask

  task automatic test_illegal();
    xfer(1'b0, 14'h3000, 32'h0, 4'hF, 1'b1);
    vectors++; if (o_ready !== 1'b1 || o_err !== 1'b1 || o_waits != 0) begin miscompares++; $display("FAIL ill_rd_resp: got ready %b err %b waits %0d want 1 1 0", o_ready, o_err, o_waits); end
    vectors++; if (o_rdata !== 32'h0) begin miscompares++; $display("FAIL ill_rd_data: got %h want 0", o_rdata); end
    vectors++; if (o_idle_err !== 1'b0) begin miscompares++; $display("FAIL ill_rd_err_pulse: got %b want 0", o_idle_err); end
    xfer(1'b1, 14'h0960, 32'hDEAD_0000, 4'hF, 1'b1);
    vectors++; if (o_ready !== 1'b1 || o_err !== 1'b1) begin miscompares++; $display("FAIL ill_wr_resp: got ready %b err %b want 1 1", o_ready, o_err); end
    vectors++; if (o_wen_cnt != 0) begin miscompares++; $display("FAIL ill_wr_wen: got %0d want 0", o_wen_cnt); end
    xfer(1'b1, 14'h1960, 32'hDEAD_0001, 4'hF, 1'b1);
    vectors++; if (o_err !== 1'b1 || o_wen_cnt != 0) begin miscompares++; $display("FAIL ill_col_wr: got err %b wen %0d want 1 0", o_err, o_wen_cnt); end
    xfer(1'b1, 14'h095C, 32'h0102_0304, 4'hF, 1'b1);
    vectors++; if (o_err !== 1'b0 || o_wen !== 3'b001 || o_ch_addr !== 10'd599) begin miscompares++; $display("FAIL last_ch_word: got err %b wen %b addr %0d want 0 001 599", o_err, o_wen, o_ch_addr); end
  endtask

  task automatic test_font_boundary();
    xfer(1'b1, 14'h2FFC, 32'hDEAD_BEEF, 4'hF, 1'b1);
    vectors++; if (o_err !== 1'b0 || o_wen !== 3'b100 || o_cht_addr !== 10'd1023) begin miscompares++; $display("FAIL wcht_top: got err %b wen %b addr %0d want 0 100 1023", o_err, o_wen, o_cht_addr); end
    xfer(1'b1, 14'h2000, 32'h1234_5678, 4'hF, 1'b1);
    xfer(1'b0, 14'h2000, 32'h0, 4'h0, 1'b0);
    vectors++; if (o_rdata !== 32'h1234_5678 || o_waits != 1) begin miscompares++; $display("FAIL b2b_rd0: got %h waits %0d want 12345678 waits 1", o_rdata, o_waits); end
    xfer(1'b0, 14'h2FFC, 32'h0, 4'h0, 1'b1);
    vectors++; if (o_setup_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_setup: got %b want 0", o_setup_ready); end
    vectors++; if (o_rdata !== 32'hDEAD_BEEF || o_waits != 1) begin miscompares++; $display("FAIL b2b_rd1: got %h waits %0d want deadbeef waits 1", o_rdata, o_waits); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 14'h0004; pstrb_i = 4'hF;
    @(negedge clk_i);
    penable_i = 1'b1;
    @(negedge clk_i);
    #1;
    vectors++; if (pready_o !== 1'b1) begin miscompares++; $display("FAIL mid_rd_wait: got %b want 1", pready_o); end
    rst_ni = 1'b0;
    #1;
    vectors++; if (pready_o !== 1'b0 || prdata_o !== 32'h0) begin miscompares++; $display("FAIL mid_rst_resp: got ready %b data %h want 0 0", pready_o, prdata_o); end
    vectors++; if (ch_map_addr_o !== 10'd0 || ch_map_be_o !== 4'h0 || ch_map_wdata_o !== 32'h0) begin miscompares++; $display("FAIL mid_rst_port: got %0d %h %h want 0 0 0", ch_map_addr_o, ch_map_be_o, ch_map_wdata_o); end
    @(negedge clk_i);
    psel_i = 1'b0; penable_i = 1'b0;
    rst_ni = 1'b1;
    xfer(1'b1, 14'h0000, 32'h55AA_55AA, 4'hF, 1'b1);
    vectors++; if (o_ready !== 1'b1 || o_waits != 0 || o_err !== 1'b0 || o_wen !== 3'b001) begin miscompares++; $display("FAIL post_rst_wr: got ready %b waits %0d err %b wen %b want 1 0 0 001", o_ready, o_waits, o_err, o_wen); end
    xfer(1'b0, 14'h0000, 32'h0, 4'h0, 1'b1);
    vectors++; if (o_rdata !== 32'h55AA_55AA || o_waits != 1) begin miscompares++; $display("FAIL post_rst_rd: got %h waits %0d want 55aa55aa waits 1", o_rdata, o_waits); end
  endtask

  task automatic test_zero_strobe();
    xfer(1'b1, 14'h0008, 32'hFFFF_FFFF, 4'h0, 1'b1);
    vectors++; if (o_ready !== 1'b1 || o_err !== 1'b0 || o_waits != 0) begin miscompares++; $display("FAIL zstrb_resp: got ready %b err %b waits %0d want 1 0 0", o_ready, o_err, o_waits); end
    vectors++; if (o_wen_cnt != 0) begin miscompares++; $display("FAIL zstrb_wen: got %0d want 0", o_wen_cnt); end
    xfer(1'b0, 14'h0008, 32'h0, 4'hF, 1'b1);
    vectors++; if (o_rdata !== 32'h0) begin miscompares++; $display("FAIL zstrb_readback: got %h want 0", o_rdata); end
  endtask

  task automatic test_abort_read();
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 14'h0004;
    @(negedge clk_i);
    penable_i = 1'b1;
    @(negedge clk_i);
    psel_i = 1'b0; penable_i = 1'b0;
    #2;
    vectors++; if (pready_o !== 1'b0 || prdata_o !== 32'h0) begin miscompares++; $display("FAIL abort_resp: got ready %b data %h want 0 0", pready_o, prdata_o); end
    xfer(1'b1, 14'h000C, 32'h0BAD_F00D, 4'hF, 1'b1);
    vectors++; if (o_ready !== 1'b1 || o_waits != 0 || o_wen !== 3'b001) begin miscompares++; $display("FAIL abort_next_wr: got ready %b waits %0d wen %b want 1 0 001", o_ready, o_waits, o_wen); end
  endtask

  initial begin
    rst_ni = 1'b0; mem_clr = 1'b1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; pstrb_i = '0;
    repeat (2) @(negedge clk_i);
    mem_clr = 1'b0;
    test_reset();
    test_write_ch_map();
    test_partial_strobe();
    test_illegal();
    test_font_boundary();
    test_reset_mid_read();
    test_zero_strobe();
    test_abort_read();
    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
